// File: rtl/zeroriscy_fetch_fifo.sv
// Instruction fetch FIFO: DEPTH 32-bit words in, halfword-aligned (optionally straddling) instructions out with PC.
// Latency: a pushed word reaches the head one cycle later; zero cycles when FETCH_FIFO_BYPASS_EN is defined.
// Backpressure: in_ready_o drops when all DEPTH entries are held; out_ready_i low simply holds the head.
module zeroriscy_fetch_fifo #(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [31:0]      clear_addr_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_rdata_i,
  output logic             in_ready_o,
  output logic [CNT_W-1:0] free_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_rdata_o,
  output logic [31:0]      out_addr_o,
  output logic             out_is_compressed_o,
  output logic             busy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointer increment that wraps at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d, rptr_p1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [31:0]      addr_q, addr_d;

  logic [31:0]      w0, w1;
  logic [CNT_W:0]   eff_cnt;
  logic             push, write, pop, pop_mem, accept, byp_consumed;
  logic             head_comp, head_valid;
  logic [31:0]      head_instr;

  assign rptr_p1    = ptr_inc(rptr_q);
  assign in_ready_o = (cnt_q != CNT_W'(DEPTH));
  assign free_o     = CNT_W'(DEPTH) - cnt_q;
  assign busy_o     = (cnt_q != '0);
  assign push       = in_valid_i && in_ready_o && !clear_i;

`ifdef FETCH_FIFO_BYPASS_EN
  // An incoming word is treated as already appended; entries not yet stored come from in_rdata_i.
  assign w0           = (cnt_q == '0) ? in_rdata_i : mem_q[rptr_q];
  assign w1           = (cnt_q <= CNT_W'(1)) ? in_rdata_i : mem_q[rptr_p1];
  assign eff_cnt      = {1'b0, cnt_q} + (CNT_W + 1)'(push);
  // With an empty FIFO, a popped head can only be the bypassed word, so it never needs storing.
  assign byp_consumed = (cnt_q == '0) && push && pop;
`else
  assign w0           = mem_q[rptr_q];
  assign w1           = mem_q[rptr_p1];
  assign eff_cnt      = {1'b0, cnt_q};
  assign byp_consumed = 1'b0;
`endif

  // Decode the head instruction from the current halfword position.
  always_comb begin
    head_comp  = 1'b0;
    head_instr = w0;
    head_valid = 1'b0;
    if (!half_q) begin
      head_comp  = (w0[1:0] != 2'b11);
      head_instr = head_comp ? {16'h0, w0[15:0]} : w0;
      head_valid = (eff_cnt >= (CNT_W + 1)'(1));
    end else if (w0[17:16] != 2'b11) begin
      head_comp  = 1'b1;
      head_instr = {16'h0, w0[31:16]};
      head_valid = (eff_cnt >= (CNT_W + 1)'(1));
    end else begin
      head_instr = {w1[15:0], w0[31:16]};
      head_valid = (eff_cnt >= (CNT_W + 1)'(2));
    end
  end

  // A flush hides the head for its own cycle so nothing from the old stream is accepted.
  assign out_valid_o         = head_valid && !clear_i;
  assign out_rdata_o         = out_valid_o ? head_instr : 32'h0;
  assign out_is_compressed_o = out_valid_o && head_comp;
  assign out_addr_o          = addr_q;

  // The head word leaves once its upper halfword has been consumed.
  assign accept  = out_valid_o && out_ready_i;
  assign pop     = accept && (half_q || !head_comp);
  assign pop_mem = pop && !byp_consumed;
  assign write   = push && !byp_consumed;

  // Next-state for pointers, occupancy, halfword position and PC; clear wins over everything.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    addr_d = addr_q;
    if (clear_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      half_d = clear_addr_i[1];
      addr_d = {clear_addr_i[31:1], 1'b0};
    end else begin
      if (write) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop_mem) begin
        rptr_d = rptr_p1;
      end
      case ({write, pop_mem})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (accept) begin
        half_d = head_comp ? !half_q : half_q;
        addr_d = addr_q + (head_comp ? 32'd2 : 32'd4);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      half_q <= 1'b0;
      addr_q <= 32'h0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      half_q <= half_d;
      addr_q <= addr_d;
    end
  end

  // Word storage; written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (write) begin
      mem_q[wptr_q] <= in_rdata_i;
    end
  end

`ifndef SYNTHESIS
  // A word offered while full (outside a flush) would be silently lost.
  assert property (@(posedge clk) disable iff (!rst_n) !(in_valid_i && !in_ready_o && !clear_i));
`endif

endmodule
